// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP read-side window sequencer.
package lbp_pkg;

  localparam int unsigned IMG_W = 128;
  localparam int unsigned IMG_H = 128;
  localparam int unsigned AW    = 14;

  typedef enum logic [2:0] {
    IDLE,
    FETCH9,
    FETCH3,
    PRESENT,
    DRAIN,
    DONE
  } state_t;

  // Neighbour byte positions inside win_nbr.
  localparam int unsigned G0 = 0;
  localparam int unsigned G1 = 1;
  localparam int unsigned G2 = 2;
  localparam int unsigned G3 = 3;
  localparam int unsigned G4 = 4;
  localparam int unsigned G5 = 5;
  localparam int unsigned G6 = 6;
  localparam int unsigned G7 = 7;

  typedef struct packed {
    logic [7:0]      center;
    logic [7:0][7:0] nbr;
  } win_t;

  // LSB of buffer cell (col,row) in the flattened column-buffer bus.
  function automatic int unsigned cell_lsb(input int unsigned c, input int unsigned r);
    return (c * 3 + r) * 8;
  endfunction

endpackage

// File: rtl/lbp_col_buf.sv
// 3x3 byte buffer of image columns; supports single-cell write and shift-left by one column.
module lbp_col_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_col,
  input  logic [1:0]  wr_row,
  input  logic [7:0]  wr_data,
  input  logic        shift,
  output logic [71:0] pix
);

  logic [2:0][2:0][7:0] cells;

  // A write in the same cycle as a shift lands after the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cells <= '0;
    end else begin
      if (shift) begin
        cells[0] <= cells[1];
        cells[1] <= cells[2];
      end
      if (wr_en) begin
        for (int c = 0; c < 3; c++) begin
          for (int r = 0; r < 3; r++) begin
            if (wr_col == 2'(c) && wr_row == 2'(r)) begin
              cells[c][r] <= wr_data;
            end
          end
        end
      end
    end
  end

  assign pix = cells;

endmodule

// File: rtl/lbp_window_ctrl.sv
// Raster-order interior-pixel walker: fetches 3x3 neighbourhoods from gray memory
// and presents them to the LBP datapath over valid/ready.
module lbp_window_ctrl
  import lbp_pkg::*;
#(
  parameter int unsigned FINISH_DLY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [7:0]    win_center,
  output logic [63:0]   win_nbr,
  output logic [AW-1:0] win_addr,
  output logic          finish
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned DW = (FINISH_DLY < 2) ? 1 : $clog2(FINISH_DLY + 1);

  state_t          state, state_nxt;
  logic [XW-1:0]   x, x_nxt;
  logic [YW-1:0]   y, y_nxt;
  logic [1:0]      col_idx, col_nxt;
  logic [1:0]      row_idx, row_nxt;
  logic [DW-1:0]   dly_cnt, dly_nxt;
  logic [AW-1:0]   waddr_nxt;
  logic [AW-1:0]   row_abs, col_abs;
  logic            shift;
  logic            fetching;
  logic [71:0]     pix;
  win_t            win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x         <= XW'(1);
      y         <= YW'(1);
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dly_cnt   <= '0;
      win_addr  <= '0;
      win_valid <= 1'b0;
      finish    <= 1'b0;
    end else begin
      state     <= state_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      col_idx   <= col_nxt;
      row_idx   <= row_nxt;
      dly_cnt   <= dly_nxt;
      win_addr  <= waddr_nxt;
      win_valid <= (state_nxt == PRESENT);
      finish    <= (state_nxt == DONE);
    end
  end

  // Next-state, traversal and read-request logic.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    col_nxt   = col_idx;
    row_nxt   = row_idx;
    dly_nxt   = dly_cnt;
    waddr_nxt = win_addr;
    gray_req  = 1'b0;
    shift     = 1'b0;
    fetching  = 1'b0;
    case (state)
      IDLE: begin
        if (gray_ready) begin
          state_nxt = FETCH9;
          col_nxt   = 2'd0;
          row_nxt   = 2'd0;
        end
      end
      FETCH9, FETCH3: begin
        fetching = 1'b1;
        gray_req = gray_ready;
        if (gray_ready) begin
          if (row_idx == 2'd2) begin
            row_nxt = 2'd0;
            if (col_idx == 2'd2) begin
              state_nxt = PRESENT;
              waddr_nxt = AW'(y) * AW'(IMG_W) + AW'(x);
            end else begin
              col_nxt = col_idx + 2'd1;
            end
          end else begin
            row_nxt = row_idx + 2'd1;
          end
        end
      end
      PRESENT: begin
        if (win_ready) begin
          if (32'(x) < IMG_W - 2) begin
            x_nxt     = x + XW'(1);
            shift     = 1'b1;
            state_nxt = FETCH3;
            col_nxt   = 2'd2;
            row_nxt   = 2'd0;
          end else if (32'(y) < IMG_H - 2) begin
            x_nxt     = XW'(1);
            y_nxt     = y + YW'(1);
            state_nxt = FETCH9;
            col_nxt   = 2'd0;
            row_nxt   = 2'd0;
          end else begin
            state_nxt = DRAIN;
            dly_nxt   = '0;
          end
        end
      end
      DRAIN: begin
        if (32'(dly_cnt) + 32'd1 >= FINISH_DLY) begin
          state_nxt = DONE;
        end else begin
          dly_nxt = dly_cnt + DW'(1);
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Current fetch cell (col_idx,row_idx) relative to the (x-1,y-1) corner.
  assign row_abs   = AW'(y) + AW'(row_idx) - AW'(1);
  assign col_abs   = AW'(x) + AW'(col_idx) - AW'(1);
  assign gray_addr = fetching ? (row_abs * AW'(IMG_W) + col_abs) : '0;

  lbp_col_buf u_col_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (gray_req),
    .wr_col  (col_idx),
    .wr_row  (row_idx),
    .wr_data (gray_data),
    .shift   (shift),
    .pix     (pix)
  );

  always_comb begin
    win         = '0;
    win.center  = pix[cell_lsb(1, 1) +: 8];
    win.nbr[G0] = pix[cell_lsb(0, 0) +: 8];
    win.nbr[G1] = pix[cell_lsb(1, 0) +: 8];
    win.nbr[G2] = pix[cell_lsb(2, 0) +: 8];
    win.nbr[G3] = pix[cell_lsb(0, 1) +: 8];
    win.nbr[G4] = pix[cell_lsb(2, 1) +: 8];
    win.nbr[G5] = pix[cell_lsb(0, 2) +: 8];
    win.nbr[G6] = pix[cell_lsb(1, 2) +: 8];
    win.nbr[G7] = pix[cell_lsb(2, 2) +: 8];
  end

  assign win_center = win.center;
  assign win_nbr    = win.nbr;

endmodule

// File: tb/tb_lbp_window_ctrl.sv
// Directed self-checking bench for lbp_window_ctrl against a behavioural image model.
module tb_lbp_window_ctrl;
  import lbp_pkg::*;

  localparam int unsigned FD = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          gray_ready = 1'b0;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          win_valid;
  logic          win_ready = 1'b0;
  logic [7:0]    win_center;
  logic [63:0]   win_nbr;
  logic [AW-1:0] win_addr;
  logic          finish;

  logic [7:0] mem [IMG_W*IMG_H];
  int n_cmp = 0;
  int n_err = 0;
  int addrs [16];
  int naddr;

  always #5 clk = ~clk;

  assign gray_data = gray_req ? mem[gray_addr] : 8'h00;

  lbp_window_ctrl #(.FINISH_DLY(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_center (win_center),
    .win_nbr    (win_nbr),
    .win_addr   (win_addr),
    .finish     (finish)
  );

  function automatic logic [7:0] px(input int y, input int x);
    return mem[AW'(y * int'(IMG_W) + x)];
  endfunction

  function automatic logic [63:0] ref_nbr(input int y, input int x);
    int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = px(y + dy[k], x + dx[k]);
    return r;
  endfunction

  // Advance until a window is presented, logging read addresses on the way.
  task automatic run_to_window(input int max_cyc, output bit ok);
    naddr = 0;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (win_valid) begin
        ok = 1'b1;
        break;
      end
      if (gray_req && naddr < 16) begin
        addrs[naddr] = int'(gray_addr);
        naddr++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    gray_ready = 1'b0;
    win_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gray_req, win_valid, finish} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000", {gray_req, win_valid, finish});
    end
    n_cmp++;
    if (gray_addr !== '0 || win_addr !== '0) begin
      n_err++; $display("FAIL reset_addr: gray_addr=%0d win_addr=%0d want 0 0", gray_addr, win_addr);
    end
    n_cmp++;
    if (win_center !== 8'h00 || win_nbr !== 64'h0) begin
      n_err++; $display("FAIL reset_window: center=%h nbr=%h want 0", win_center, win_nbr);
    end
  endtask

  task automatic test_first_windows();
    int exp9 [9] = '{0, 128, 256, 1, 129, 257, 2, 130, 258};
    int exp3 [3] = '{3, 131, 259};
    bit ok;
    gray_ready = 1'b1;
    win_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_to_window(40, ok);
    n_cmp++;
    if (!ok || naddr != 9) begin
      n_err++; $display("FAIL first_fetch_count: ok=%0d reads=%0d want 1 9", ok, naddr);
    end
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (addrs[i] !== exp9[i]) begin
        n_err++; $display("FAIL first_addr[%0d]: got %0d want %0d", i, addrs[i], exp9[i]);
      end
    end
    n_cmp++;
    if (win_addr !== AW'(129) || win_center !== mem[129]) begin
      n_err++; $display("FAIL first_win: addr=%0d center=%h want 129 %h", win_addr, win_center, mem[129]);
    end
    n_cmp++;
    if (win_nbr[7:0] !== mem[0] || win_nbr[63:56] !== mem[258] || win_nbr !== ref_nbr(1, 1)) begin
      n_err++; $display("FAIL first_nbr: got %h want %h", win_nbr, ref_nbr(1, 1));
    end
    run_to_window(20, ok);
    n_cmp++;
    if (!ok || naddr != 3) begin
      n_err++; $display("FAIL second_fetch_count: ok=%0d reads=%0d want 1 3", ok, naddr);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (addrs[i] !== exp3[i]) begin
        n_err++; $display("FAIL second_addr[%0d]: got %0d want %0d", i, addrs[i], exp3[i]);
      end
    end
    n_cmp++;
    if (win_addr !== AW'(130) || win_nbr[7:0] !== mem[1] || win_nbr[31:24] !== mem[129] ||
        win_nbr[39:32] !== mem[131] || win_center !== mem[130]) begin
      n_err++; $display("FAIL second_win: addr=%0d nbr=%h want 130 %h", win_addr, win_nbr, ref_nbr(1, 2));
    end
  endtask

  task automatic test_row_wrap();
    int exp9 [9] = '{128, 256, 384, 129, 257, 385, 130, 258, 386};
    bit ok;
    bit found;
    found = 1'b0;
    for (int w = 0; w < 130 && !found; w++) begin
      run_to_window(20, ok);
      if (ok && win_addr == AW'(254)) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL wrap_reach254: got last addr %0d want 254", win_addr);
    end
    run_to_window(40, ok);
    n_cmp++;
    if (!ok || naddr != 9) begin
      n_err++; $display("FAIL wrap_fetch_count: ok=%0d reads=%0d want 1 9", ok, naddr);
    end
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (addrs[i] !== exp9[i]) begin
        n_err++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, addrs[i], exp9[i]);
      end
    end
    n_cmp++;
    if (win_addr !== AW'(257) || win_nbr !== ref_nbr(2, 1) || win_center !== px(2, 1)) begin
      n_err++; $display("FAIL wrap_win: addr=%0d nbr=%h want 257 %h", win_addr, win_nbr, ref_nbr(2, 1));
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a0;
    logic [7:0]    c0;
    logic [63:0]   n0;
    bit ok;
    @(negedge clk);
    win_ready = 1'b0;
    run_to_window(20, ok);
    a0 = win_addr; c0 = win_center; n0 = win_nbr;
    n_cmp++;
    if (!ok || a0 !== AW'(258) || n0 !== ref_nbr(2, 2) || c0 !== px(2, 2)) begin
      n_err++; $display("FAIL bp_window: addr=%0d nbr=%h want 258 %h", a0, n0, ref_nbr(2, 2));
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (win_valid !== 1'b1 || gray_req !== 1'b0 || win_addr !== a0 ||
          win_center !== c0 || win_nbr !== n0) begin
        n_err++; $display("FAIL bp_hold[%0d]: valid=%b req=%b addr=%0d want 1 0 %0d",
                          i, win_valid, gray_req, win_addr, a0);
      end
    end
    @(negedge clk);
    win_ready = 1'b1;
    n_cmp++;
    if (win_valid !== 1'b1 || win_nbr !== n0) begin
      n_err++; $display("FAIL bp_accept: valid=%b want 1", win_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (win_valid !== 1'b0 || gray_req !== 1'b1 || gray_addr !== AW'(132)) begin
      n_err++; $display("FAIL bp_fetch3: valid=%b req=%b addr=%0d want 0 1 132", win_valid, gray_req, gray_addr);
    end
  endtask

  task automatic test_gray_stall();
    int reads;
    bit ok;
    reset = 1'b1;
    gray_ready = 1'b1;
    win_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reads = 0;
    for (int i = 0; i < 20 && reads < 4; i++) begin
      @(negedge clk);
      if (gray_req) reads++;
    end
    n_cmp++;
    if (reads != 4 || gray_addr !== AW'(1)) begin
      n_err++; $display("FAIL stall_4th_read: reads=%0d addr=%0d want 4 1", reads, gray_addr);
    end
    @(negedge clk);
    gray_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (gray_req !== 1'b0 || gray_addr !== AW'(129)) begin
        n_err++; $display("FAIL stall_hold[%0d]: req=%b addr=%0d want 0 129", i, gray_req, gray_addr);
      end
    end
    @(negedge clk);
    gray_ready = 1'b1;
    #1;
    n_cmp++;
    if (gray_req !== 1'b1 || gray_addr !== AW'(129)) begin
      n_err++; $display("FAIL stall_resume: req=%b addr=%0d want 1 129", gray_req, gray_addr);
    end
    run_to_window(20, ok);
    n_cmp++;
    if (!ok || win_addr !== AW'(129) || win_center !== px(1, 1) || win_nbr !== ref_nbr(1, 1)) begin
      n_err++; $display("FAIL stall_window: addr=%0d nbr=%h want 129 %h", win_addr, win_nbr, ref_nbr(1, 1));
    end
  endtask

  task automatic test_full_frame();
    int hs, ex, ey, last;
    bit done;
    for (int i = 0; i < int'(IMG_W * IMG_H); i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    gray_ready = 1'b1;
    win_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hs = 0; ex = 1; ey = 1; last = -1; done = 1'b0;
    for (int c = 0; c < 70000 && !done; c++) begin
      @(negedge clk);
      if (win_valid && win_ready) begin
        n_cmp++;
        if (win_addr !== AW'(ey * int'(IMG_W) + ex) || win_center !== px(ey, ex) ||
            win_nbr !== ref_nbr(ey, ex)) begin
          n_err++; $display("FAIL frame_win(%0d,%0d): addr=%0d nbr=%h want %0d %h",
                            ey, ex, win_addr, win_nbr, ey * int'(IMG_W) + ex, ref_nbr(ey, ex));
        end
        hs++;
        last = int'(win_addr);
        if (ex < int'(IMG_W) - 2) ex++;
        else begin ex = 1; ey++; end
        if (hs == 15876) done = 1'b1;
      end
    end
    n_cmp++;
    if (hs != 15876 || last != 16254) begin
      n_err++; $display("FAIL frame_count: handshakes=%0d last=%0d want 15876 16254", hs, last);
    end
    repeat (FD) begin
      @(negedge clk);
      n_cmp++;
      if (finish !== 1'b0) begin
        n_err++; $display("FAIL finish_early: got %b want 0", finish);
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (finish !== 1'b1 || win_valid !== 1'b0 || gray_req !== 1'b0) begin
        n_err++; $display("FAIL finish_hold[%0d]: finish=%b valid=%b req=%b want 1 0 0",
                          i, finish, win_valid, gray_req);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit seen;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (finish !== 1'b0 || win_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_clear_finish: finish=%b valid=%b want 0 0", finish, win_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    win_ready = 1'b0;
    run_to_window(40, ok);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (!ok || win_valid !== 1'b0 || gray_req !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_frame: reached=%0d valid=%b req=%b want 1 0 0", ok, win_valid, gray_req);
    end
    @(negedge clk);
    reset = 1'b0;
    win_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (gray_req) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || gray_addr !== '0) begin
      n_err++; $display("FAIL rst_restart: req_seen=%0d addr=%0d want 1 0", seen, gray_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(IMG_W * IMG_H); i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 7));
    test_reset();
    test_first_windows();
    test_row_wrap();
    test_backpressure();
    test_gray_stall();
    test_full_frame();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbp_window_ctrl.md
Name: lbp_window_ctrl

Overview:
- Read-side sequencer for the 128x128 LBP engine.
- Walks every interior pixel of the gray image in raster order and issues 8-bit gray-memory reads.
- Assembles each 3x3 neighbourhood in a sliding column buffer and hands center, 8 neighbours and target LBP address to the compute datapath over a valid/ready handshake.
- Raises finish when the frame is complete. Border pixels are never presented; the output memory is pre-cleared to 0.

Parameters:
- IMG_W, 128, image width in pixels
- IMG_H, 128, image height in pixels
- AW, 14, address width (log2 of IMG_W*IMG_H)
- FINISH_DLY, 1, cycles between last window handshake and finish (covers datapath latency)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- gray_ready  in  1  gray memory available; reads allowed only while high
- gray_req  out  1  read request this cycle
- gray_addr  out  AW  read address, y*IMG_W+x
- gray_data  in  8  read data, valid in the request cycle (zero latency), sampled at the rising edge ending it
- win_valid  out  1  window presented
- win_ready  in  1  datapath accepts window
- win_center  out  8  pixel (y,x)
- win_nbr  out  64  neighbours; byte k = g_k with g0..g7 = (y-1,x-1),(y-1,x),(y-1,x+1),(y,x-1),(y,x+1),(y+1,x-1),(y+1,x),(y+1,x+1)
- win_addr  out  AW  LBP output address y*IMG_W+x
- finish  out  1  frame done, sticky until reset

Behaviour:
- Reset (async, any state): state=IDLE; x=1, y=1; gray_req, gray_addr, win_valid, win_center, win_nbr, win_addr and finish all 0. This aborts any frame in progress; the next frame starts from (1,1).
- IDLE: wait for gray_ready=1, then go to FETCH9.
- FETCH9 (row start): 9 reads, column-major. Columns are x-1, x, x+1; within a column rows y-1, y, y+1. Each read stores into buffer col[c][r]. Then go to PRESENT.
- FETCH3 (slide): buffer columns have already shifted left (col0<=col1, col1<=col2). 3 reads of column x+1, rows y-1, y, y+1, into col2. Then go to PRESENT.
- Read rule: gray_req = (state is FETCH9 or FETCH3) && gray_ready. A read completes only in a cycle with gray_req=1. When gray_ready is low, gray_req is 0, the fetch counter and gray_addr hold, and the sequence resumes on the same address.
- PRESENT: win_valid=1. win_center, win_nbr and win_addr are stable while win_valid=1 && win_ready=0. No reads are issued in PRESENT.
- Handshake in PRESENT (win_valid && win_ready):
  - if x<IMG_W-2: x++, shift buffer, go to FETCH3
  - else if y<IMG_H-2: x=1, y++, go to FETCH9
  - else go to DRAIN
- win_valid drops in the cycle after the handshake unless re-presented; the earliest re-present is 4 cycles later (3 reads).
- DRAIN: count FINISH_DLY cycles, then go to DONE.
- DONE: finish=1, gray_req=0, win_valid=0. Holds until reset.
- Cycle budget with gray_ready and win_ready tied high, per row: 10 + 125*4 = 510 cycles. Frame: 126 rows = 64260 cycles plus the IDLE exit and FINISH_DLY.
- Address arithmetic: unsigned AW bits computed as y*IMG_W+x±offset. There is no wrap, because interior-only traversal keeps every address in 0..IMG_W*IMG_H-1.
- win_ready high outside PRESENT is ignored. gray_data is ignored when gray_req=0 (may be Z/X).

Decomposition:
- Shared package lbp_pkg holds:
  - IMG_W, IMG_H, AW
  - state enum {IDLE, FETCH9, FETCH3, PRESENT, DRAIN, DONE}
  - neighbour index constants G0..G7
  - the window struct (center + 8 neighbours)
- One natural sub-module: lbp_col_buf, a 3x3 byte buffer with write(col,row) and shift-left.

Test Plan:
- Reset, then gray_ready=1 and win_ready=1 held. Required:
  - first 9 gray_addr values are 0,128,256,1,129,257,2,130,258
  - first window has win_addr=129, win_center=mem[129], g0=mem[0], g7=mem[258]
- Second window: only 3 reads, at addresses 3,131,259. Required: win_addr=130, g0=mem[1], g3=mem[129], g4=mem[131].
- Row wrap: after the window with win_addr=254, the next reads are 128,256,384,129,257,385,130,258,386. Required: next win_addr=257.
- Backpressure: hold win_ready=0 for 5 cycles during PRESENT. Required: win_valid stays 1, all window outputs unchanged, gray_req=0. Accept on cycle 6; FETCH3 follows.
- gray_ready low for 3 cycles after the 4th read of FETCH9. Required: gray_req=0 and gray_addr frozen at 129; reads resume at 129 and the window contents match the stall-free run.
- Full frame on random image versus a reference model. Required:
  - exactly 15876 handshakes; last win_addr=16254
  - finish rises FINISH_DLY cycles after the last handshake and stays 1
  - a reset asserted mid-frame clears finish/win_valid immediately and restarts at gray_addr=0
